// File: rtl/blip_pkg.sv
// Shared definitions for the blip count reader.
//   state_t           : reader FSM states (IDLE, CLR, RUN, READ)
//   CNT_W_DEF         : default width of the external count bus
//   READ_TIMEOUT_DEF  : default READ cycle budget before a read is abandoned
package blip_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2,
        READ = 2'd3
    } state_t;

    localparam int CNT_W_DEF        = 8;
    localparam int READ_TIMEOUT_DEF = 15;

endpackage

// File: rtl/blip_count_reader_stable_sampler.sv
// Brings the asynchronous count bus into the system clock domain and
// qualifies a read by requiring STABLE_N consecutive equal synchronized
// samples. A read attempt lasts as long as `en` is held high.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   cnt        : raw count bus from pins (asynchronous)
//   en         : high for every cycle of a read attempt
//   accept     : combinational pulse, the current read is stable now
//   timeout    : combinational pulse, READ_TIMEOUT cycles without acceptance
//   value      : synchronized count (valid when accept is high)
module stable_sampler
    import blip_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int STABLE_N     = 2,
    parameter int READ_TIMEOUT = READ_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cnt,
    input  logic             en,
    output logic             accept,
    output logic             timeout,
    output logic [CNT_W-1:0] value
);

    localparam int MW = $clog2(STABLE_N + 1) + 1;
    localparam int TW = $clog2(READ_TIMEOUT + 1) + 1;

    logic [CNT_W-1:0] meta;
    logic [CNT_W-1:0] sync;
    logic [CNT_W-1:0] prev;
    logic             en_q;
    logic [MW-1:0]    match;
    logic [MW-1:0]    match_nx;
    logic [TW-1:0]    cyc;
    logic [TW-1:0]    cyc_nx;
    logic             first;

    // The synchronizer and the previous-value register run continuously so
    // the comparison in the first READ cycle already sees a settled history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta  <= '0;
            sync  <= '0;
            prev  <= '0;
            en_q  <= 1'b0;
            match <= '0;
            cyc   <= '0;
        end else begin
            meta <= cnt;
            sync <= meta;
            prev <= sync;
            en_q <= en;
            if (en) begin
                match <= match_nx;
                cyc   <= cyc_nx;
            end
        end
    end

    // A rising edge of en marks the first READ cycle, which always restarts
    // both counters regardless of what the history registers hold.
    always_comb begin
        first    = en && !en_q;
        match_nx = (first || (sync != prev)) ? MW'(1) : match + MW'(1);
        cyc_nx   = first ? TW'(1) : cyc + TW'(1);
        accept   = en && (match_nx == MW'(STABLE_N));
        timeout  = en && !accept && (cyc_nx == TW'(READ_TIMEOUT));
        value    = sync;
    end

endmodule

// File: rtl/blip_count_reader.sv
// Host-side reader for the free-running external blip counter. Resets the
// counter, periodically samples its pins through stable_sampler, and folds
// wrap-aware deltas into a saturating total.
// Ports:
//   wb_clk_i, wb_rst_ni : system clock, asynchronous active-low reset
//   cnt_i               : external count bus (asynchronous)
//   start_i, stop_i     : one-cycle pulses starting / ending a run
//   cnt_rst_o           : active-high reset to the external counter
//   busy_o              : high whenever the FSM is not IDLE
//   valid_o             : one-cycle pulse when delta_o/total_o update
//   delta_o, total_o    : last accepted increment, saturating total
//   overflow_o          : sticky, total has saturated
//   glitch_o            : sticky, a read timed out
module blip_count_reader
    import blip_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int ACC_W        = 16,
    parameter int SAMPLE_DIV   = 16,
    parameter int STABLE_N     = 2,
    parameter int RST_CYCLES   = 4,
    parameter int READ_TIMEOUT = READ_TIMEOUT_DEF
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             start_i,
    input  logic             stop_i,
    output logic             cnt_rst_o,
    output logic             busy_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] delta_o,
    output logic [ACC_W-1:0] total_o,
    output logic             overflow_o,
    output logic             glitch_o
);

    localparam int TMW = $clog2(SAMPLE_DIV + 1);
    localparam int RW  = $clog2(RST_CYCLES + 1);

    state_t           state;
    logic [TMW-1:0]   timer;
    logic [RW-1:0]    rst_cnt;
    logic [CNT_W-1:0] last;
    logic             en;
    logic             accept;
    logic             timeout;
    logic [CNT_W-1:0] value;
    logic [CNT_W-1:0] d;
    logic [ACC_W:0]   sat;

    // Returns {clamped, result}; assumes CNT_W <= ACC_W so a single carry bit
    // is enough to detect that the sum exceeded the maximum.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc,
                                               input logic [CNT_W-1:0] inc);
        logic [ACC_W:0] sum;
        sum = {1'b0, acc} + (ACC_W + 1)'(inc);
        if (sum[ACC_W]) begin
            return {1'b1, {ACC_W{1'b1}}};
        end
        return sum;
    endfunction

    stable_sampler #(
        .CNT_W       (CNT_W),
        .STABLE_N    (STABLE_N),
        .READ_TIMEOUT(READ_TIMEOUT)
    ) u_sampler (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_ni),
        .cnt    (cnt_i),
        .en     (en),
        .accept (accept),
        .timeout(timeout),
        .value  (value)
    );

    assign en     = (state == READ);
    assign busy_o = (state != IDLE);
    // Modular subtraction absorbs a single wrap of the external counter.
    assign d      = value - last;
    assign sat    = sat_add(total_o, d);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state      <= IDLE;
            timer      <= '0;
            rst_cnt    <= '0;
            last       <= '0;
            cnt_rst_o  <= 1'b0;
            valid_o    <= 1'b0;
            delta_o    <= '0;
            total_o    <= '0;
            overflow_o <= 1'b0;
            glitch_o   <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i && !stop_i) begin
                        state      <= CLR;
                        rst_cnt    <= RW'(RST_CYCLES);
                        last       <= '0;
                        delta_o    <= '0;
                        total_o    <= '0;
                        overflow_o <= 1'b0;
                        glitch_o   <= 1'b0;
                    end
                end
                // cnt_rst_o rises one cycle after entry and is held for
                // RST_CYCLES cycles before RUN begins.
                CLR: begin
                    if (stop_i) begin
                        state     <= IDLE;
                        cnt_rst_o <= 1'b0;
                    end else if (rst_cnt == '0) begin
                        state     <= RUN;
                        cnt_rst_o <= 1'b0;
                        timer     <= TMW'(SAMPLE_DIV - 1);
                    end else begin
                        cnt_rst_o <= 1'b1;
                        rst_cnt   <= rst_cnt - RW'(1);
                    end
                end
                RUN: begin
                    if (stop_i) begin
                        state <= IDLE;
                    end else if (timer == '0) begin
                        state <= READ;
                    end else begin
                        timer <= timer - TMW'(1);
                    end
                end
                READ: begin
                    if (stop_i) begin
                        state <= IDLE;
                    end else if (accept) begin
                        state      <= RUN;
                        timer      <= TMW'(SAMPLE_DIV - 1);
                        last       <= value;
                        delta_o    <= d;
                        total_o    <= sat[ACC_W-1:0];
                        overflow_o <= overflow_o | sat[ACC_W];
                        valid_o    <= 1'b1;
                    end else if (timeout) begin
                        state    <= RUN;
                        timer    <= TMW'(SAMPLE_DIV - 1);
                        glitch_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
